slurm16_cpu_prefetch: RTL and testbench

Parametrised instruction prefetch buffer between instruction memory and the slurm16 pipeline fetch slot. It replaces the fixed one-cycle, always-valid instruction path with a request/response memory handshake, several requests in flight, and an in-order FIFO of fetched words. Branch/(i)ret PC loads flush the buffer and squash in-flight responses, so memory latency and pipeline stalls are decoupled.

---
 rtl/slurm16_cpu_pkg.sv | 12 +
 rtl/slurm16_sync_fifo.sv | 61 ++++++
 rtl/slurm16_cpu_prefetch.sv | 136 +++++++++++++
 tb/tb_slurm16_cpu_prefetch.sv | 339 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/slurm16_cpu_pkg.sv
// rtl/slurm16_cpu_pkg.sv - shared types and default widths for the slurm16 fetch path
package slurm16_cpu_pkg;

    localparam int SLURM16_ADDR_BITS = 15;
    localparam int SLURM16_DATA_BITS = 16;

    typedef enum logic {
        IDLE = 1'b0,
        RUN  = 1'b1
    } prefetch_state_t;

endpackage

// File: rtl/slurm16_sync_fifo.sv
// rtl/slurm16_sync_fifo.sv - register-based synchronous FIFO with flush and occupancy count
// Push while full is accepted only when a pop frees the slot in the same cycle.
module slurm16_sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4,
    localparam int PW = $clog2(DEPTH),
    localparam int CW = PW + 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    input  logic             flush,
    output logic [WIDTH-1:0] head_data,
    output logic             empty,
    output logic [CW-1:0]    count
);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [PW-1:0]    r_wr_ptr;
    logic [PW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign w_pop  = pop && (r_count != '0);
    assign w_push = push && ((r_count != CW'(DEPTH)) || w_pop);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else if (flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + 1'b1;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + 1'b1;
            end
            r_count <= r_count + CW'(w_push) - CW'(w_pop);
        end
    end

    // Storage needs no reset: count gates every read of it.
    always_ff @(posedge clk) begin
        if (w_push && !flush) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

    assign head_data = r_mem[r_rd_ptr];
    assign empty     = (r_count == '0);
    assign count     = r_count;

endmodule

// File: rtl/slurm16_cpu_prefetch.sv
// rtl/slurm16_cpu_prefetch.sv - instruction prefetch buffer with in-order memory handshake and flush
// Words in flight plus words buffered never exceed DEPTH, so the output FIFO cannot overflow.
module slurm16_cpu_prefetch
    import slurm16_cpu_pkg::*;
#(
    parameter int ADDR_BITS = SLURM16_ADDR_BITS,
    parameter int DATA_BITS = SLURM16_DATA_BITS,
    parameter int DEPTH = 4,
    parameter logic [ADDR_BITS-1:0] RESET_PC = '0,
    localparam int CW = $clog2(DEPTH) + 1
) (
    input  logic                 CLK,
    input  logic                 RST,
    output logic                 mem_request,
    output logic [ADDR_BITS-1:0] mem_address,
    input  logic                 mem_ready,
    input  logic                 mem_valid,
    input  logic [DATA_BITS-1:0] mem_data,
    output logic                 instruction_valid,
    output logic [DATA_BITS-1:0] instruction_out,
    output logic [ADDR_BITS-1:0] instruction_address_out,
    input  logic                 instruction_ready,
    input  logic                 load_pc_request,
    input  logic [ADDR_BITS-1:0] load_pc_address,
    output logic [CW-1:0]        occupancy
);

    localparam logic [CW:0] CREDIT_LIMIT = (CW + 1)'(DEPTH);

    prefetch_state_t r_state;
    prefetch_state_t w_state_next;

    logic [ADDR_BITS-1:0] r_fetch_pc;
    logic [CW-1:0]        r_discard;
    logic [CW-1:0]        w_occupancy;
    logic [CW-1:0]        w_in_flight;
    logic [CW:0]          w_committed;
    logic                 w_aq_empty;
    logic                 w_fifo_empty;
    logic [ADDR_BITS-1:0] w_resp_addr;
    logic [ADDR_BITS-1:0] w_head_addr;
    logic [DATA_BITS-1:0] w_head_data;
    logic                 w_run;
    logic                 w_flush;
    logic                 w_request;
    logic                 w_accept;
    logic                 w_resp;
    logic                 w_drop;
    logic                 w_push;
    logic                 w_pop;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        w_run        = 1'b0;
        case (r_state)
            IDLE: w_state_next = RUN;
            RUN:  w_run        = 1'b1;
        endcase
    end

    assign w_committed = {1'b0, w_occupancy} + {1'b0, w_in_flight};
    assign w_flush     = w_run && load_pc_request;
    assign w_request   = w_run && !load_pc_request && (w_committed < CREDIT_LIMIT);
    assign w_accept    = w_request && mem_ready;
    assign w_resp      = mem_valid && !w_aq_empty;
    assign w_drop      = w_resp && (r_discard != '0);
    assign w_push      = w_resp && !w_drop && !w_flush;
    assign w_pop       = !w_fifo_empty && instruction_ready && !w_flush;

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_fetch_pc <= RESET_PC;
            r_discard  <= '0;
        end else begin
            if (w_flush) begin
                r_fetch_pc <= load_pc_address;
            end else if (w_accept) begin
                r_fetch_pc <= r_fetch_pc + 1'b1;
            end
            // Every request still outstanding after a flush belongs to the old stream.
            if (w_flush) begin
                r_discard <= w_in_flight - CW'(w_resp);
            end else if (w_drop) begin
                r_discard <= r_discard - 1'b1;
            end
        end
    end

    slurm16_sync_fifo #(
        .WIDTH(ADDR_BITS),
        .DEPTH(DEPTH)
    ) u_addr_queue (
        .clk      (CLK),
        .rst      (RST),
        .push     (w_accept),
        .push_data(r_fetch_pc),
        .pop      (w_resp),
        .flush    (1'b0),
        .head_data(w_resp_addr),
        .empty    (w_aq_empty),
        .count    (w_in_flight)
    );

    slurm16_sync_fifo #(
        .WIDTH(ADDR_BITS + DATA_BITS),
        .DEPTH(DEPTH)
    ) u_insn_fifo (
        .clk      (CLK),
        .rst      (RST),
        .push     (w_push),
        .push_data({w_resp_addr, mem_data}),
        .pop      (w_pop),
        .flush    (w_flush),
        .head_data({w_head_addr, w_head_data}),
        .empty    (w_fifo_empty),
        .count    (w_occupancy)
    );

    assign mem_request             = w_request;
    assign mem_address             = w_run ? r_fetch_pc : '0;
    assign instruction_valid       = !w_fifo_empty;
    assign instruction_out         = w_fifo_empty ? '0 : w_head_data;
    assign instruction_address_out = w_fifo_empty ? '0 : w_head_addr;
    assign occupancy               = w_occupancy;

    a_resp_needs_request : assert property (@(posedge CLK) disable iff (RST) !(mem_valid && w_aq_empty));

endmodule

// File: tb/tb_slurm16_cpu_prefetch.sv
// tb/tb_slurm16_cpu_prefetch.sv - self-checking bench for the slurm16 prefetch buffer
module tb_slurm16_cpu_prefetch;

    localparam int DEPTH = 4;

    logic        CLK;
    logic        RST;
    logic        mem_request;
    logic [14:0] mem_address;
    logic        mem_ready;
    logic        mem_valid;
    logic [15:0] mem_data;
    logic        instruction_valid;
    logic [15:0] instruction_out;
    logic [14:0] instruction_address_out;
    logic        instruction_ready;
    logic        load_pc_request;
    logic [14:0] load_pc_address;
    logic [2:0]  occupancy;

    slurm16_cpu_prefetch #(
        .ADDR_BITS(15),
        .DATA_BITS(16),
        .DEPTH(DEPTH),
        .RESET_PC(15'h0000)
    ) dut (
        .CLK                    (CLK),
        .RST                    (RST),
        .mem_request            (mem_request),
        .mem_address            (mem_address),
        .mem_ready              (mem_ready),
        .mem_valid              (mem_valid),
        .mem_data               (mem_data),
        .instruction_valid      (instruction_valid),
        .instruction_out        (instruction_out),
        .instruction_address_out(instruction_address_out),
        .instruction_ready      (instruction_ready),
        .load_pc_request        (load_pc_request),
        .load_pc_address        (load_pc_address),
        .occupancy              (occupancy)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed { logic [14:0] addr; logic stale; } fl_t;
    typedef struct { logic [14:0] addr; int due; } mq_t;
    typedef struct { bit req; logic [14:0] addr; bit ivalid; logic [14:0] iaddr; logic [2:0] occ; } vec_t;

    int errors = 0;
    int checks = 0;

    // Reference model: fetch pointer, outstanding requests (flagged stale on redirect), buffered words.
    bit          m_run;
    logic [14:0] m_pc;
    fl_t         m_fl[$];
    logic [14:0] m_buf[$];

    mq_t         mq[$];
    int          cyc = 0;
    int          lat = 1;
    int          rdy_mode = 0;
    int          pipe_mode = 0;
    bit          flush_now = 0;
    logic [14:0] flush_addr = '0;
    bit          prev_stalled = 0;
    logic [14:0] prev_addr = '0;

    function automatic logic [15:0] word_of(input logic [14:0] a);
        return {1'b1, a[6:0], a[14:7]} ^ 16'h5A3C;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic drive();
        case (rdy_mode)
            0:       mem_ready = 1'b1;
            1:       mem_ready = cyc[0];
            default: mem_ready = 1'($urandom_range(0, 1));
        endcase
        case (pipe_mode)
            0:       instruction_ready = 1'b1;
            1:       instruction_ready = 1'b0;
            default: instruction_ready = 1'($urandom_range(0, 1));
        endcase
        load_pc_request = flush_now;
        load_pc_address = flush_addr;
        flush_now = 1'b0;
        if (mq.size() != 0 && mq[0].due <= cyc) begin
            mem_valid = 1'b1;
            mem_data  = word_of(mq[0].addr);
        end else begin
            mem_valid = 1'b0;
            mem_data  = 16'($urandom);
        end
    endtask

    task automatic step();
        bit          exp_req;
        bit          acc_m;
        bit          pop_m;
        bit          fl;
        bit          acc_dut;
        logic [14:0] acc_addr;
        fl_t         f;
        exp_req = m_run && !load_pc_request && ((m_buf.size() + m_fl.size()) < DEPTH);
        check("mem_request", 32'(mem_request), 32'(exp_req));
        if (exp_req) check("mem_address", 32'(mem_address), 32'(m_pc));
        if (prev_stalled && mem_request) check("mem_address_hold", 32'(mem_address), 32'(prev_addr));
        check("instruction_valid", 32'(instruction_valid), 32'(m_buf.size() != 0));
        if (m_buf.size() != 0) begin
            check("instruction_address_out", 32'(instruction_address_out), 32'(m_buf[0]));
            check("instruction_out", 32'(instruction_out), 32'(word_of(m_buf[0])));
        end
        check("occupancy", 32'(occupancy), 32'(m_buf.size()));

        acc_dut      = mem_request && mem_ready;
        acc_addr     = mem_address;
        prev_stalled = mem_request && !mem_ready;
        prev_addr    = mem_address;

        fl    = m_run && load_pc_request;
        acc_m = exp_req && mem_ready;
        pop_m = (m_buf.size() != 0) && instruction_ready && !fl;
        if (pop_m) void'(m_buf.pop_front());
        if (mem_valid && m_fl.size() != 0) begin
            f = m_fl.pop_front();
            if (!f.stale && !fl) m_buf.push_back(f.addr);
        end
        if (fl) begin
            m_buf.delete();
            for (int i = 0; i < m_fl.size(); i++) begin
                f = m_fl[i];
                f.stale = 1'b1;
                m_fl[i] = f;
            end
            m_pc = load_pc_address;
        end else if (acc_m) begin
            m_fl.push_back('{addr: m_pc, stale: 1'b0});
            m_pc = m_pc + 15'd1;
        end
        m_run = 1'b1;

        @(posedge CLK);
        #1;
        cyc++;
        if (mem_valid) void'(mq.pop_front());
        if (acc_dut) mq.push_back('{addr: acc_addr, due: cyc + lat - 1});
    endtask

    task automatic cycle();
        drive();
        #2;
        step();
    endtask

    task automatic model_clear();
        mq.delete();
        m_fl.delete();
        m_buf.delete();
        m_run = 1'b0;
        m_pc = 15'h0000;
        prev_stalled = 1'b0;
    endtask

    vec_t        tbl[6];
    logic [14:0] seen[$];
    bit          got;

    initial begin
        RST = 1'b1;
        mem_ready = 1'b0;
        mem_valid = 1'b0;
        mem_data = '0;
        instruction_ready = 1'b0;
        load_pc_request = 1'b0;
        load_pc_address = '0;

        tbl[0] = '{1'b0, 15'd0, 1'b0, 15'd0, 3'd0};
        tbl[1] = '{1'b1, 15'd0, 1'b0, 15'd0, 3'd0};
        tbl[2] = '{1'b1, 15'd1, 1'b0, 15'd0, 3'd0};
        tbl[3] = '{1'b1, 15'd2, 1'b1, 15'd0, 3'd1};
        tbl[4] = '{1'b1, 15'd3, 1'b1, 15'd1, 3'd1};
        tbl[5] = '{1'b1, 15'd4, 1'b1, 15'd2, 3'd1};

        #3;
        check("reset_mem_request", 32'(mem_request), 32'd0);
        check("reset_instruction_valid", 32'(instruction_valid), 32'd0);
        check("reset_occupancy", 32'(occupancy), 32'd0);
        model_clear();
        @(posedge CLK);
        #1;
        RST = 1'b0;

        // Fill latency and streaming order with a one-cycle memory.
        for (int i = 0; i < 6; i++) begin
            drive();
            #2;
            check($sformatf("tbl%0d_req", i), 32'(mem_request), 32'(tbl[i].req));
            if (tbl[i].req) check($sformatf("tbl%0d_addr", i), 32'(mem_address), 32'(tbl[i].addr));
            check($sformatf("tbl%0d_ivalid", i), 32'(instruction_valid), 32'(tbl[i].ivalid));
            if (tbl[i].ivalid) begin
                check($sformatf("tbl%0d_iaddr", i), 32'(instruction_address_out), 32'(tbl[i].iaddr));
                check($sformatf("tbl%0d_idata", i), 32'(instruction_out), 32'(word_of(tbl[i].iaddr)));
            end
            check($sformatf("tbl%0d_occ", i), 32'(occupancy), 32'(tbl[i].occ));
            step();
        end
        repeat (6) cycle();

        // Pipeline stall fills the buffer and stops requests.
        pipe_mode = 1;
        repeat (10) cycle();
        drive();
        #2;
        check("stall_occupancy", 32'(occupancy), 32'(DEPTH));
        check("stall_mem_request", 32'(mem_request), 32'd0);
        step();
        pipe_mode = 0;
        repeat (12) cycle();

        // Flush with three requests outstanding on a 3-cycle memory.
        lat = 3;
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            if (m_fl.size() == 3) got = 1'b1;
        end
        check("reach_three_in_flight", 32'(got), 32'd1);
        flush_now = 1'b1;
        flush_addr = 15'h0040;
        cycle();
        drive();
        #2;
        check("flush_valid_low", 32'(instruction_valid), 32'd0);
        step();
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            drive();
            #2;
            if (instruction_valid) begin
                check("flush_first_addr", 32'(instruction_address_out), 32'h40);
                check("flush_first_data", 32'(instruction_out), 32'(word_of(15'h0040)));
                got = 1'b1;
            end
            step();
        end
        check("flush_delivery", 32'(got), 32'd1);

        // Memory ready toggling: address held while unaccepted.
        rdy_mode = 1;
        repeat (20) cycle();
        rdy_mode = 0;

        // Back-to-back redirects, last one near the top of the address space.
        lat = 1;
        flush_now = 1'b1;
        flush_addr = 15'h1234;
        cycle();
        flush_now = 1'b1;
        flush_addr = 15'h7FFE;
        cycle();
        seen.delete();
        for (int i = 0; i < 30 && seen.size() < 3; i++) begin
            drive();
            #2;
            if (instruction_valid && instruction_ready) seen.push_back(instruction_address_out);
            step();
        end
        check("wrap_count", 32'(seen.size()), 32'd3);
        if (seen.size() == 3) begin
            check("wrap_addr0", 32'(seen[0]), 32'h7FFE);
            check("wrap_addr1", 32'(seen[1]), 32'h7FFF);
            check("wrap_addr2", 32'(seen[2]), 32'h0000);
        end

        // Reset with two words buffered and two outstanding.
        lat = 3;
        pipe_mode = 1;
        flush_now = 1'b1;
        flush_addr = 15'h0300;
        cycle();
        got = 1'b0;
        for (int i = 0; i < 30 && !got; i++) begin
            cycle();
            if (m_buf.size() == 2 && m_fl.size() == 2) got = 1'b1;
        end
        check("reach_reset_point", 32'(got), 32'd1);
        drive();
        #1;
        RST = 1'b1;
        #1;
        check("rst_mem_request", 32'(mem_request), 32'd0);
        check("rst_mem_address", 32'(mem_address), 32'd0);
        check("rst_instruction_valid", 32'(instruction_valid), 32'd0);
        check("rst_instruction_out", 32'(instruction_out), 32'd0);
        check("rst_instruction_address_out", 32'(instruction_address_out), 32'd0);
        check("rst_occupancy", 32'(occupancy), 32'd0);
        mem_valid = 1'b0;
        model_clear();
        @(posedge CLK);
        #1;
        RST = 1'b0;
        pipe_mode = 0;
        lat = 1;
        drive();
        #2;
        check("post_reset_idle", 32'(mem_request), 32'd0);
        step();
        drive();
        #2;
        check("post_reset_req", 32'(mem_request), 32'd1);
        check("post_reset_addr", 32'(mem_address), 32'd0);
        step();
        repeat (10) cycle();

        // Randomised traffic against the model.
        rdy_mode = 2;
        pipe_mode = 2;
        for (int i = 0; i < 800; i++) begin
            if (i % 100 == 0) lat = int'($urandom_range(1, 4));
            if ($urandom_range(0, 19) == 0) begin
                flush_now = 1'b1;
                flush_addr = 15'($urandom);
            end
            cycle();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
